freq_meter: RTL

Measures the frequency of an asynchronous, slow input signal by counting its rising edges over a fixed gate window of `GATE_CYCLES` system clocks, then publishes the count. It consumes clock-divider outputs such as the 1 kHz tick, the 1 Hz second tick and external pulse inputs. It also serves as the on-board self-check that the divider chain produces the intended rate. One measurement completes per gate window, repeating while enabled.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/sig_edge_sync.sv | 36 +++
 rtl/freq_meter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and the clock-divider blocks.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } fm_state_t;

  localparam int SYS_CLK_HZ          = 100000000;
  localparam int DEFAULT_GATE_CYCLES = 100000000;
  localparam int DEFAULT_CNT_W       = 16;

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchronizer plus rising-edge pulse for an asynchronous input.
// Reusable for buttons and other slow asynchronous signals.
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift the input through the synchronizer and keep the previous sample.
  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter: counts SIG edges over GATE_CYCLES clocks and publishes FREQ.
// Define FREQ_METER_OVF_EN for a saturating edge counter with a sticky OVF flag.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SIG,
  output logic [CNT_W-1:0] FREQ,
  output logic             VALID,
  output logic             OVF,
  output logic             BUSY
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  fm_state_t         state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              rise;
`ifdef FREQ_METER_OVF_EN
  logic              sat_q, sat_d;
  logic              ovf_q, ovf_d;
`endif

  sig_edge_sync u_sync (
    .clk    (CK),
    .rst    (RST),
    .sig_in (SIG),
    .rise   (rise)
  );

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    freq_d  = freq_q;
    valid_d = 1'b0;
`ifdef FREQ_METER_OVF_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        gate_d = '0;
        edge_d = '0;
`ifdef FREQ_METER_OVF_EN
        sat_d  = 1'b0;
`endif
        if (EN) begin
          state_d = ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!EN) begin
          state_d = ST_IDLE;
          gate_d  = '0;
          edge_d  = '0;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          if (rise) begin
`ifdef FREQ_METER_OVF_EN
            if (edge_q == {CNT_W{1'b1}}) begin
              sat_d = 1'b1;
            end else begin
              edge_d = edge_q + CNT_W'(1);
            end
`else
            edge_d = edge_q + CNT_W'(1);
`endif
          end else begin
            edge_d = edge_q;
          end
          // The edge seen in the last gate cycle is already folded into edge_d.
          if (gate_q == GATE_LAST) begin
            state_d = ST_DONE;
            freq_d  = edge_d;
            valid_d = 1'b1;
`ifdef FREQ_METER_OVF_EN
            ovf_d   = sat_d;
`endif
          end else begin
            state_d = ST_COUNT;
          end
        end
      end
      ST_DONE: begin
        gate_d = '0;
        edge_d = '0;
`ifdef FREQ_METER_OVF_EN
        sat_d  = 1'b0;
`endif
        if (EN) begin
          state_d = ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gate_d  = '0;
        edge_d  = '0;
      end
    endcase
    busy_d = (state_d == ST_COUNT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FREQ_METER_OVF_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef FREQ_METER_OVF_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign FREQ  = freq_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
`ifdef FREQ_METER_OVF_EN
  assign OVF   = ovf_q;
`else
  assign OVF   = 1'b0;
`endif

endmodule
